// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path types and constants
package mips_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, instr} fetch entries with flush
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Dropping everything: collapse the write pointer onto the read pointer.
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: push_pc, instr: push_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_pc    = mem_q[rd_ptr_q].pc;
    assign head_instr = mem_q[rd_ptr_q].instr;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC/FSM owner feeding decode from the instruction ROM
// Optional performance counters enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ROM_BYTES  = 32,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_done,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);
    localparam logic [31:0] STEP      = 32'(WORD_BYTES);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          misalign_q, misalign_d;
    logic          done_q, done_d;
    logic          push, pop;
    logic [31:0]   redirect_target;
    logic [CW-1:0] fifo_count;
    logic [31:0]   head_pc, head_instr;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign if_valid        = (fifo_count != '0) && !redirect_valid;
    assign pop             = if_valid && id_ready;
    assign push            = (state_q == RUN) && (pc_q < ROM_LIMIT) && !redirect_valid
                             && ((fifo_count < DEPTH_C) || pop);

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (push) begin
            pc_d = pc_q + STEP;
        end
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (pc_d >= ROM_LIMIT) state_d = DONE;
            DONE:    if (redirect_valid && (redirect_target < ROM_LIMIT)) state_d = RUN;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            done_q     <= done_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (pc_q),
        .push_instr (imem_instr),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign imem_pc      = pc_q;
    assign if_pc        = head_pc;
    assign if_instr     = head_instr;
    // Gated so the output reads zero out of reset; the value is don't-care when empty.
    assign if_pc_plus4  = (fifo_count != '0) ? head_pc + STEP : 32'h0;
    assign fetch_done   = done_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        perf_flush_d   = perf_flush_q;
        if (push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 1'b1;
        if (if_valid && !id_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 1'b1;
        if (redirect_valid && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        fetch_done;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC   (32'h0),
        .ROM_BYTES  (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4),
        .fetch_done     (fetch_done),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr < 32'd32) ? (32'hA000_0000 | addr) : 32'h0;
    endfunction

    // ROM reads as zero while reset is held.
    assign imem_instr = reset ? rom_word(imem_pc) : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, rom_word(pc));
        check({tag, "_plus4"}, if_pc_plus4, pc + 32'd4);
    endtask

    // Pulse reset, release it, and advance to the first visible entry (pc 0).
    task automatic restart();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_idle_valid", {31'b0, if_valid}, 32'd0);
        step();
        check_head("rst_first", 32'h0);
    endtask

    initial begin
        reset          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();

        check("reset_if_valid", {31'b0, if_valid}, 32'd0);
        check("reset_imem_pc", imem_pc, 32'h0);
        check("reset_if_pc", if_pc, 32'h0);
        check("reset_if_instr", if_instr, 32'h0);
        check("reset_plus4", if_pc_plus4, 32'h0);
        check("reset_done", {31'b0, fetch_done}, 32'd0);
        check("reset_misalign", {31'b0, misalign_err}, 32'd0);

        // Scenario 1: straight-line fetch of the whole ROM.
        reset = 1'b1;
        step();
        check("s1_idle_valid", {31'b0, if_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check_head("s1", 32'(4 * k));
            if (k < 7) check("s1_not_done", {31'b0, fetch_done}, 32'd0);
        end
        check("s1_done", {31'b0, fetch_done}, 32'd1);
        step();
        check("s1_drained", {31'b0, if_valid}, 32'd0);
        check("s1_done_hold", {31'b0, fetch_done}, 32'd1);

        // Scenario 2: decode stall from pc 8.
        restart();
        step();
        check_head("s2_pre", 32'h4);
        step();
        check_head("s2_pre", 32'h8);
        id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_head("s2_stall", 32'h8);
            check("s2_imem_frozen", imem_pc, 32'h10);
        end
        id_ready = 1'b1;
        step();
        check_head("s2_rel", 32'hC);
        step();
        check_head("s2_rel", 32'h10);
        check("s2_imem", imem_pc, 32'h18);

        // Scenario 3: redirect to 4 while the FIFO is full (16, 20 held).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        #1;
        check("s3_valid_forced", {31'b0, if_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        check("s3_flushed", {31'b0, if_valid}, 32'd0);
        check("s3_imem", imem_pc, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("s3_perf_flush", perf_flush, 32'd1);
`endif
        step();
        check_head("s3_target", 32'h4);
        step();
        check_head("s3_next", 32'h8);

        // Scenario 4: redirect in a cycle where decode would pop.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        #1;
        check("s4_valid_forced", {31'b0, if_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        check("s4_flushed", {31'b0, if_valid}, 32'd0);
        step();
        check_head("s4_target", 32'h14);

        // Scenario 5: misaligned redirect, then run to DONE, then out-of-range redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        step();
        redirect_valid = 1'b0;
        check("s5_misalign", {31'b0, misalign_err}, 32'd1);
        check("s5_imem", imem_pc, 32'h4);
        for (int k = 1; k < 8; k++) begin
            step();
            check_head("s5", 32'(4 * k));
        end
        check("s5_done", {31'b0, fetch_done}, 32'd1);
        step();
        check("s5_drained", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("s5_oor_imem", imem_pc, 32'h40);
        check("s5_oor_done", {31'b0, fetch_done}, 32'd1);
        check("s5_oor_valid", {31'b0, if_valid}, 32'd0);
        step();
        check("s5_oor_done2", {31'b0, fetch_done}, 32'd1);
        check("s5_oor_valid2", {31'b0, if_valid}, 32'd0);
        check("s5_misalign_sticky", {31'b0, misalign_err}, 32'd1);

        // Scenario 6: reset mid-stream with one entry buffered.
        restart();
        step();
        check_head("s6_pre", 32'h4);
        reset = 1'b0;
        #1;
        check("s6_valid", {31'b0, if_valid}, 32'd0);
        check("s6_imem", imem_pc, 32'h0);
        check("s6_done", {31'b0, fetch_done}, 32'd0);
        check("s6_misalign", {31'b0, misalign_err}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("s6_idle_valid", {31'b0, if_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_head("s6_restart", 32'(4 * k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
